// File: rtl/costas_loop_filter.sv
// PI loop filter for the Costas carrier-recovery loop: phase error in, NCO frequency correction out.
// Optional lock detector compiled in with `define COSTAS_LOCK_DET_EN.
module costas_loop_filter #(
    parameter int WIDTH       = 16,
    parameter int ACC_WIDTH   = 24,
    parameter int LOCK_THRESH = 2048,
    parameter int LOCK_COUNT  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [3:0]       KP_SHIFT,
    input  logic [3:0]       KI_SHIFT,
    input  logic [WIDTH-1:0] error_tdata,
    input  logic             error_tvalid,
    output logic [WIDTH-1:0] feedback_tdata,
    output logic             feedback_tvalid,
    output logic             sat,
    output logic             locked
);
    localparam int PAD = ACC_WIDTH - WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] e_scaled, prop, integ_inc;
    logic signed [ACC_WIDTH-1:0] integ, prop_r, integ_sat, sum_sat;
    logic signed [ACC_WIDTH:0]   integ_wide, sum_wide;
    logic                        integ_clip, sum_clip;
    logic                        v1, sat1, clr_pend, clr_eff;

    always_comb begin
        e_scaled   = $signed({error_tdata, {PAD{1'b0}}});
        prop       = e_scaled >>> KP_SHIFT;
        integ_inc  = e_scaled >>> KI_SHIFT;
        integ_wide = {integ[ACC_WIDTH-1], integ} + {integ_inc[ACC_WIDTH-1], integ_inc};
        integ_clip = integ_wide[ACC_WIDTH] != integ_wide[ACC_WIDTH-1];
        integ_sat  = integ_clip ? (integ_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                : integ_wide[ACC_WIDTH-1:0];
        // Stage 2 reads the integrator after its own sample's update.
        sum_wide   = {prop_r[ACC_WIDTH-1], prop_r} + {integ[ACC_WIDTH-1], integ};
        sum_clip   = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
        sum_sat    = sum_clip ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                              : sum_wide[ACC_WIDTH-1:0];
        clr_eff    = clear | clr_pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ           <= '0;
            prop_r          <= '0;
            v1              <= 1'b0;
            sat1            <= 1'b0;
            clr_pend        <= 1'b0;
            feedback_tdata  <= '0;
            feedback_tvalid <= 1'b0;
            sat             <= 1'b0;
        end else if (enable) begin
            clr_pend        <= 1'b0;
            v1              <= error_tvalid;
            feedback_tvalid <= v1;
            if (clr_eff)
                integ <= '0;
            else if (error_tvalid)
                integ <= integ_sat;
            if (error_tvalid) begin
                prop_r <= prop;
                sat1   <= integ_clip & ~clr_eff;
            end
            if (v1) begin
                feedback_tdata <= WIDTH'(sum_sat >>> PAD);
                sat            <= sat1 | sum_clip;
            end
        end else begin
            // A clear seen while frozen is remembered for the next enabled cycle.
            feedback_tvalid <= 1'b0;
            if (clear)
                clr_pend <= 1'b1;
        end
    end

`ifdef COSTAS_LOCK_DET_EN
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(LOCK_COUNT);
    localparam logic [WIDTH:0] THRESH  = (WIDTH+1)'(LOCK_THRESH);

    logic signed [WIDTH:0] err_ext;
    logic        [WIDTH:0] err_abs;
    logic        [CW-1:0]  lock_cnt, lock_cnt_next;

    always_comb begin
        err_ext       = {error_tdata[WIDTH-1], error_tdata};
        err_abs       = err_ext[WIDTH] ? -err_ext : err_ext;
        lock_cnt_next = (lock_cnt == CNT_MAX) ? CNT_MAX : lock_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (enable && error_tvalid) begin
            if (err_abs < THRESH) begin
                lock_cnt <= lock_cnt_next;
                locked   <= (lock_cnt_next == CNT_MAX);
            end else begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end
        end
    end
`else
    assign locked = 1'b0;
`endif
endmodule

// File: tb/tb_costas_loop_filter.sv
// Scoreboard bench for costas_loop_filter: directed samples with hand-computed corrections.
module tb_costas_loop_filter;
    logic        clk = 1'b0;
    logic        rst, enable, clear, error_tvalid;
    logic [3:0]  kp_shift, ki_shift;
    logic [15:0] error_tdata;
    logic [15:0] feedback_tdata;
    logic        feedback_tvalid, sat, locked;

    typedef struct {
        logic [15:0] d;
        logic        s;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    costas_loop_filter #(.WIDTH(16), .ACC_WIDTH(24), .LOCK_THRESH(2048), .LOCK_COUNT(256)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .KP_SHIFT(kp_shift), .KI_SHIFT(ki_shift),
        .error_tdata(error_tdata), .error_tvalid(error_tvalid),
        .feedback_tdata(feedback_tdata), .feedback_tvalid(feedback_tvalid),
        .sat(sat), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step(input logic en, input logic v, input logic [15:0] e, input logic clr);
        enable = en; error_tvalid = v; error_tdata = e; clear = clr;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [15:0] d, input logic s);
        exp_t x;
        x.d = d; x.s = s;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; error_tvalid = 1'b0; clear = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: every presented output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && feedback_tvalid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {16'h0, feedback_tdata}, 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("fb_data", {16'h0, feedback_tdata}, {16'h0, x.d});
                chk("fb_sat", {31'h0, sat}, {31'h0, x.s});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        kp_shift = 4'd2; ki_shift = 4'd6; error_tdata = '0;
        rst = 1'b1; enable = 1'b1; clear = 1'b0; error_tvalid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_data", {16'h0, feedback_tdata}, 32'h0);
        chk("rst_valid", {31'h0, feedback_tvalid}, 32'h0);
        chk("rst_sat", {31'h0, sat}, 32'h0);
        chk("rst_locked", {31'h0, locked}, 32'h0);
        rst = 1'b0;

        // Basic PI response and two-clock latency
        push(16'd1088, 1'b0);
        step(1'b1, 1'b1, 16'h1000, 1'b0);
        chk("latency_early", {31'h0, feedback_tvalid}, 32'h0);
        push(16'd1152, 1'b0);
        step(1'b1, 1'b1, 16'h1000, 1'b0);
        chk("latency_2clk", {31'h0, feedback_tvalid}, 32'h1);
        idle(3);

        // Positive and negative saturation
        do_reset();
        kp_shift = 4'd0; ki_shift = 4'd0;
        for (int i = 0; i < 3; i++) begin
            push(16'h7FFF, 1'b1);
            step(1'b1, 1'b1, 16'h7FFF, 1'b0);
        end
        idle(3);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push(16'h8000, 1'b1);
            step(1'b1, 1'b1, 16'h8000, 1'b0);
        end
        idle(3);

        // Valid gaps and a 3-clock enable stall with a sample held in stage 1
        do_reset();
        kp_shift = 4'd2; ki_shift = 4'd6;
        push(16'd1088, 1'b0); push(16'd608, 1'b0); push(16'hFC20, 1'b0); push(16'd304, 1'b0);
        step(1'b1, 1'b1, 16'h1000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 16'h0800, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hF000, 1'b0);
        step(1'b1, 1'b1, 16'hF000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 16'h0400, 1'b0);
        idle(3);

        // Clear coincident with a sample
        do_reset();
        push(16'd1088, 1'b0);
        step(1'b1, 1'b1, 16'h1000, 1'b0);
        push(16'd1024, 1'b0);
        step(1'b1, 1'b1, 16'h1000, 1'b1);
        push(16'd1088, 1'b0);
        step(1'b1, 1'b1, 16'h1000, 1'b0);
        idle(3);

        // Reset with samples in flight
        step(1'b1, 1'b1, 16'h1000, 1'b0);
        rst = 1'b1; error_tvalid = 1'b1; error_tdata = 16'h1000;
        @(posedge clk); #1;
        rst = 1'b0; error_tvalid = 1'b0;
        chk("rst_flush_data", {16'h0, feedback_tdata}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            chk("rst_flush_valid", {31'h0, feedback_tvalid}, 32'h0);
            step(1'b1, 1'b0, 16'h0000, 1'b0);
        end
        chk("rst_flush_valid", {31'h0, feedback_tvalid}, 32'h0);
        chk("rst_flush_sat", {31'h0, sat}, 32'h0);
        push(16'd1088, 1'b0);
        step(1'b1, 1'b1, 16'h1000, 1'b0);
        idle(3);

`ifdef COSTAS_LOCK_DET_EN
        do_reset();
        kp_shift = 4'd15; ki_shift = 4'd15;
        for (int n = 1; n <= 256; n++) begin
            push(16'((15 + 15 * n) >> 8), 1'b0);
            step(1'b1, 1'b1, 16'h07FF, 1'b0);
            if (n == 255) chk("lock_255", {31'h0, locked}, 32'h0);
            if (n == 256) chk("lock_256", {31'h0, locked}, 32'h1);
        end
        push(16'd13, 1'b0);
        step(1'b1, 1'b1, 16'h8000, 1'b0);
        chk("lock_drop", {31'h0, locked}, 32'h0);
        idle(3);
`else
        chk("locked_tied", {31'h0, locked}, 32'h0);
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("drain", q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
